// File: rtl/imm_gen_pkg.sv
// Shared definitions for the RV32I immediate generator: opcode constants,
// field widths and the immediate-format code.
package imm_gen_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned OPC_W = 7;
  localparam int unsigned FMT_W = 3;

  // Major opcodes (instr[6:0]) recognised by the immediate generator
  localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;
  localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
  localparam logic [OPC_W-1:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;
  localparam logic [OPC_W-1:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [OPC_W-1:0] OPC_FENCE  = 7'b0001111;
  localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
  localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
  localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
  localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;

  // Immediate format code as presented on fmt_o
  typedef enum logic [FMT_W-1:0] {
    FMT_NONE    = 3'd0,
    FMT_I       = 3'd1,
    FMT_S       = 3'd2,
    FMT_B       = 3'd3,
    FMT_U       = 3'd4,
    FMT_J       = 3'd5,
    FMT_UNKNOWN = 3'd7
  } fmt_e;

endpackage

// File: rtl/imm_decode.sv
// Combinational RV32I immediate decode.
// Ports:
//   instr   - raw 32-bit instruction word
//   imm     - sign-extended immediate (zero when the format has none)
//   fmt     - format code (see fmt_e)
//   illegal - opcode is not in the supported set
module imm_decode
  import imm_gen_pkg::*;
(
  input  logic [XLEN-1:0]  instr,
  output logic [XLEN-1:0]  imm,
  output logic [FMT_W-1:0] fmt,
  output logic             illegal
);

  fmt_e fmt_sel;
  logic s;

  assign s   = instr[31];
  assign fmt = fmt_sel;

  // Opcode classification; funct3/funct7 play no part
  always_comb begin
    fmt_sel = FMT_UNKNOWN;
    illegal = 1'b1;
    case (instr[OPC_W-1:0])
      OPC_OP: begin
        fmt_sel = FMT_NONE;
        illegal = 1'b0;
      end
      OPC_LOAD, OPC_OPIMM, OPC_JALR, OPC_SYSTEM, OPC_FENCE: begin
        fmt_sel = FMT_I;
        illegal = 1'b0;
      end
      OPC_STORE: begin
        fmt_sel = FMT_S;
        illegal = 1'b0;
      end
      OPC_BRANCH: begin
        fmt_sel = FMT_B;
        illegal = 1'b0;
      end
      OPC_LUI, OPC_AUIPC: begin
        fmt_sel = FMT_U;
        illegal = 1'b0;
      end
      OPC_JAL: begin
        fmt_sel = FMT_J;
        illegal = 1'b0;
      end
      default: begin
        fmt_sel = FMT_UNKNOWN;
        illegal = 1'b1;
      end
    endcase
  end

  // Immediate assembly per format; shift immediates are passed through whole
  always_comb begin
    imm = '0;
    case (fmt_sel)
      FMT_I:   imm = {{20{s}}, instr[31:20]};
      FMT_S:   imm = {{20{s}}, instr[31:25], instr[11:7]};
      FMT_B:   imm = {{19{s}}, s, instr[7], instr[30:25], instr[11:8], 1'b0};
      FMT_U:   imm = {instr[31:12], 12'b0};
      FMT_J:   imm = {{11{s}}, s, instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/imm_gen.sv
// RV32I immediate generator with one registered pipeline stage.
// Ports:
//   clk, rst_n - rising-edge clock, asynchronous active-low reset
//   valid_i    - instr_i carries an instruction this cycle
//   instr_i    - raw 32-bit instruction word
//   valid_o    - imm_o/fmt_o/illegal_o hold the decode of the last accepted instruction
//   imm_o      - sign-extended immediate
//   fmt_o      - format code (0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 7 UNKNOWN)
//   illegal_o  - unsupported opcode
module imm_gen
  import imm_gen_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_i,
  input  logic [XLEN-1:0]  instr_i,
  output logic             valid_o,
  output logic [XLEN-1:0]  imm_o,
  output logic [FMT_W-1:0] fmt_o,
  output logic             illegal_o
);

  logic [XLEN-1:0]  dec_imm;
  logic [FMT_W-1:0] dec_fmt;
  logic             dec_illegal;

  imm_decode u_decode (
    .instr   (instr_i),
    .imm     (dec_imm),
    .fmt     (dec_fmt),
    .illegal (dec_illegal)
  );

  // Output stage: valid follows valid_i every cycle, payload only loads on valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_o   <= 1'b0;
      imm_o     <= '0;
      fmt_o     <= '0;
      illegal_o <= 1'b0;
    end else begin
      valid_o <= valid_i;
      if (valid_i) begin
        imm_o     <= dec_imm;
        fmt_o     <= dec_fmt;
        illegal_o <= dec_illegal;
      end
    end
  end

endmodule

// File: tb/tb_imm_gen.sv
// Scoreboard bench for imm_gen: a driver issues directed and random
// instructions and queues the expected decode; a monitor on the falling
// edge compares DUT outputs against the queue and against held values.
module tb_imm_gen;

  typedef struct {
    logic [31:0] imm;
    logic [2:0]  fmt;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_i = 1'b0;
  logic [31:0] instr_i = 32'h0;
  logic        valid_o;
  logic [31:0] imm_o;
  logic [2:0]  fmt_o;
  logic        illegal_o;

  int   errors = 0;
  int   checks = 0;
  int   cycles = 0;
  bit   done   = 1'b0;
  exp_t sb[$];
  exp_t hold = '{32'h0, 3'd0, 1'b0};

  imm_gen dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid_i   (valid_i),
    .instr_i   (instr_i),
    .valid_o   (valid_o),
    .imm_o     (imm_o),
    .fmt_o     (fmt_o),
    .illegal_o (illegal_o)
  );

  always #5 clk = ~clk;

  // Reference model: immediates built from field arithmetic on the word
  function automatic exp_t model(input logic [31:0] w);
    exp_t e;
    int   u;
    int   sx;
    u  = int'(w);
    sx = int'(w) >>> 31;
    e.ill = 1'b0;
    e.imm = 32'h0;
    case (u & 127)
      51:                e.fmt = 3'd0;
      3, 19, 103, 115, 15: begin
        e.fmt = 3'd1;
        e.imm = 32'(int'(w) >>> 20);
      end
      35: begin
        e.fmt = 3'd2;
        e.imm = 32'(((int'(w) >>> 25) << 5) | ((u >> 7) & 31));
      end
      99: begin
        e.fmt = 3'd3;
        e.imm = 32'((sx << 12) | (((u >> 7) & 1) << 11) | (((u >> 25) & 63) << 5)
                    | (((u >> 8) & 15) << 1));
      end
      55, 23: begin
        e.fmt = 3'd4;
        e.imm = 32'(u & 32'hFFFFF000);
      end
      111: begin
        e.fmt = 3'd5;
        e.imm = 32'((sx << 20) | (((u >> 12) & 255) << 12) | (((u >> 20) & 1) << 11)
                    | (((u >> 21) & 1023) << 1));
      end
      default: begin
        e.fmt = 3'd7;
        e.ill = 1'b1;
      end
    endcase
    return e;
  endfunction

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, req, $time);
    end
  endfunction

  // Monitor: reset clears everything, valid_o pops, otherwise payload holds
  always @(negedge clk) begin
    cycles++;
    if (!rst_n) begin
      chk("rst_valid", 32'(valid_o), 32'h0);
      chk("rst_imm", imm_o, 32'h0);
      chk("rst_fmt", 32'(fmt_o), 32'h0);
      chk("rst_ill", 32'(illegal_o), 32'h0);
      sb.delete();
      hold = '{32'h0, 3'd0, 1'b0};
    end else if (valid_o) begin
      if (sb.size() == 0) begin
        chk("spurious_valid", 32'(valid_o), 32'h0);
      end else begin
        hold = sb.pop_front();
        chk("imm", imm_o, hold.imm);
        chk("fmt", 32'(fmt_o), 32'(hold.fmt));
        chk("illegal", 32'(illegal_o), 32'(hold.ill));
      end
    end else begin
      chk("missing_valid", 32'(sb.size()), 32'h0);
      chk("hold_imm", imm_o, hold.imm);
      chk("hold_fmt", 32'(fmt_o), 32'(hold.fmt));
      chk("hold_ill", 32'(illegal_o), 32'(hold.ill));
    end
    if (done || cycles > 5000) begin
      if (!done) chk("timeout", 32'(cycles), 32'd5000);
      chk("queue_drained", 32'(sb.size()), 32'h0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
    end
  end

  // Drive one cycle; the expectation is queued once the capturing edge has passed
  task automatic drive(input logic v, input logic [31:0] w, input bit push, input exp_t e);
    valid_i = v;
    instr_i = w;
    @(posedge clk);
    if (push) sb.push_back(e);
    #1;
  endtask

  task automatic send_exp(input logic [31:0] w, input logic [31:0] imm, input logic [2:0] fmt,
                          input logic ill);
    exp_t e;
    e.imm = imm;
    e.fmt = fmt;
    e.ill = ill;
    drive(1'b1, w, 1'b1, e);
  endtask

  task automatic send_rand(input logic [31:0] w);
    drive(1'b1, w, 1'b1, model(w));
  endtask

  task automatic idle(input logic [31:0] w);
    drive(1'b0, w, 1'b0, '{32'h0, 3'd0, 1'b0});
  endtask

  logic [6:0] opcs [11] = '{7'b0110011, 7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011,
                            7'b0001111, 7'b0100011, 7'b1100011, 7'b0110111, 7'b0010111,
                            7'b1101111};

  initial begin
    logic [31:0] w;
    logic [6:0]  op;
    // Held in reset while a valid instruction is presented
    @(posedge clk); #1;
    drive(1'b1, 32'h0F052483, 1'b0, '{32'h0, 3'd0, 1'b0});
    drive(1'b1, 32'h0F052483, 1'b0, '{32'h0, 3'd0, 1'b0});
    rst_n = 1'b1;
    send_exp(32'h0F052483, 32'h000000F0, 3'd1, 1'b0);
    send_exp(32'h015A04B3, 32'h00000000, 3'd0, 1'b0);
    send_exp(32'h009A84B3, 32'h00000000, 3'd0, 1'b0);
    send_exp(32'h00148493, 32'h00000001, 3'd1, 1'b0);
    send_exp(32'h06952C23, 32'h00000078, 3'd2, 1'b0);
    send_exp(32'hFFF00093, 32'hFFFFFFFF, 3'd1, 1'b0);
    send_exp(32'hFE000EE3, 32'hFFFFFFFC, 3'd3, 1'b0);
    send_exp(32'h123450B7, 32'h12345000, 3'd4, 1'b0);
    send_exp(32'h0080006F, 32'h00000008, 3'd5, 1'b0);
    send_exp(32'h0000007F, 32'h00000000, 3'd7, 1'b1);
    idle(32'hFFF00093);
    idle(32'h123450B7);
    // Randomized mix of legal and arbitrary opcodes with idle gaps
    for (int i = 0; i < 300; i++) begin
      w = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        op = opcs[$urandom_range(0, 10)];
        w  = {w[31:7], op};
      end
      if ($urandom_range(0, 4) == 0) idle(w);
      else send_rand(w);
    end
    // Asynchronous reset between edges while valid_o is high
    send_exp(32'hFFF00093, 32'hFFFFFFFF, 3'd1, 1'b0);
    #2;
    rst_n   = 1'b0;
    valid_i = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    send_rand(32'h80000063);
    send_rand(32'h800000EF);
    idle(32'h0);
    idle(32'h0);
    done = 1'b1;
  end

endmodule
